wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive crypto-blocked cycles that forces a pipeline stall (legal range 1..15).
REQ-002 SHALL have port clk_in  input  1  single clock; all logic updates on the rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wb_reg_wr_in  input  1  pipeline write-back request.
REQ-005 SHALL have port wb_addr_in  input  4  pipeline destination register.
REQ-006 SHALL have port wb_data_in  input  16  pipeline write data, already muxed between ALU and load.
REQ-007 SHALL have port cx_req_in  input  1  crypto unit requests a result burst.
REQ-008 SHALL have port cx_base_addr_in  input  4  first destination register of the burst.
REQ-009 SHALL have port cx_len_in  input  3  burst length in words.
REQ-010 SHALL have port cx_data_in  input  16  current crypto result word.
REQ-011 SHALL have port cx_pop_out  output  1  current crypto word is consumed this cycle.
REQ-012 SHALL have port cx_done_out  output  1  one-cycle pulse when the burst completes.
REQ-013 SHALL have port rf_wr_en_out  output  1  register-file write enable.
REQ-014 SHALL have port rf_wr_addr_out  output  4  register-file write address.
REQ-015 SHALL have port rf_wr_data_out  output  16  register-file write data.
REQ-016 SHALL have port stall_out  output  1  freeze pipeline stages upstream of WB.
REQ-017 SHALL have port busy_out  output  1  a burst is in progress (state not IDLE).

Function
REQ-018 SHALL implement the states IDLE, XFER and FORCE.
REQ-019 IDLE to XFER SHALL occur when cx_req_in=1 and cx_len_in!=0; the arbiter latches base address, length and idx=0.
- cx_len_in=0: request ignored.
- cx_len_in 5..7: clamped to 4.
REQ-020 cx_req_in SHALL be sampled only in IDLE.
REQ-021 Pipeline write SHALL always win: when wb_reg_wr_in=1, the next-cycle rf_wr_* carry wb_addr_in/wb_data_in, in any state.
REQ-022 In XFER or FORCE with wb_reg_wr_in=0, the arbiter SHALL:
- assert cx_pop_out combinationally;
- register cx_data_in to addr (base+idx) mod 16 on the next cycle;
- increment idx.
REQ-023 rf_wr_* SHALL be registered, with 1-cycle latency from the selected source; rf_wr_en_out=0 when there is no source.
REQ-024 When the last word (idx=len-1) is popped, the arbiter SHALL pulse cx_done_out in the same cycle and return to IDLE next cycle; a new request is accepted no earlier than the following cycle.
REQ-025 In XFER, each cycle with wb_reg_wr_in=1 SHALL increment starve_cnt; a crypto pop SHALL clear it; reaching STARVE_LIMIT SHALL move XFER to FORCE.
REQ-026 In FORCE, stall_out SHALL be 1 combinationally; a wb_reg_wr_in still asserted (in flight) SHALL still win; FORCE exits to IDLE after the last pop.
REQ-027 In IDLE and XFER, stall_out SHALL be 0; starve_cnt SHALL clear on entering IDLE.
REQ-028 Address wrap SHALL be modulo 16 (e.g. base 14, len 4 -> regs 14, 15, 0, 1).

Reset
REQ-029 rst_in=1 SHALL immediately force, regardless of clock:
- state=IDLE;
- idx, starve_cnt, rf_wr_en_out, rf_wr_addr_out, rf_wr_data_out, cx_done_out, stall_out, busy_out to 0.
REQ-030 Reset mid-burst SHALL abandon the burst with no cx_done_out pulse and no further writes; cx_pop_out=0 while in reset.

Configuration
REQ-031 With macro WB_STARVE_GUARD_EN defined, the starve counter and FORCE state SHALL exist as specified.
REQ-032 Without WB_STARVE_GUARD_EN, these SHALL apply:
- starve_cnt and FORCE are absent;
- stall_out is tied 0;
- a crypto burst waits indefinitely behind pipeline writes.

Verification
REQ-033 Idle pipeline: cx_req_in=1, base=3, len=2, data 0xAAAA then 0x5555 -> writes r3=0xAAAA, r4=0x5555 on consecutive cycles; cx_done_out pulses with the 2nd pop; busy_out drops next cycle.
REQ-034 Collision: burst active with wb_reg_wr_in=1, addr=7, data=0x1234 in the same cycle -> r7=0x1234 written, cx_pop_out=0, crypto word written the following free cycle.
REQ-035 Starvation (macro on, STARVE_LIMIT=4): wb_reg_wr_in held 1 during a len=3 burst -> stall_out=1 after 4 blocked cycles; once wb_reg_wr_in drops, 3 pops; stall_out=0 after done.
REQ-036 Wrap and clamp: base=15, cx_len_in=7 -> 4 writes to r15, r0, r1, r2; len=0 request -> no busy_out, no writes.
REQ-037 Reset mid-burst: rst_in pulsed after 1st pop of a len=4 burst -> all outputs 0 asynchronously, no cx_done_out, state IDLE, new request accepted after release.
REQ-038 Macro off: repeat the REQ-035 stimulus -> stall_out stays 0 and the burst completes only after wb_reg_wr_in drops.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back always wins, crypto result bursts fill free cycles.
// Optional starvation guard (starve counter + FORCE stall state) enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        wb_reg_wr_in,
    input  logic [3:0]  wb_addr_in,
    input  logic [15:0] wb_data_in,
    input  logic        cx_req_in,
    input  logic [3:0]  cx_base_addr_in,
    input  logic [2:0]  cx_len_in,
    input  logic [15:0] cx_data_in,
    output logic        cx_pop_out,
    output logic        cx_done_out,
    output logic        rf_wr_en_out,
    output logic [3:0]  rf_wr_addr_out,
    output logic [15:0] rf_wr_data_out,
    output logic        stall_out,
    output logic        busy_out,
    output logic [1:0]  state_dbg_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef WB_STARVE_GUARD_EN
        ST_FORCE = 2'd2,
`endif
        ST_XFER  = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  base_q, base_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic        rf_wr_en_q, rf_wr_en_d;
    logic [3:0]  rf_wr_addr_q, rf_wr_addr_d;
    logic [15:0] rf_wr_data_q, rf_wr_data_d;
    logic        pop;
    logic        last;

`ifdef WB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);
    logic [3:0]  starve_q, starve_d;
`endif

    // Handshake: cx_data_in is valid throughout a burst; cx_pop_out is the ready/consume
    // strobe, high in any cycle the write port is free while a burst is active.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        idx_d        = idx_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
`ifdef WB_STARVE_GUARD_EN
        starve_d     = starve_q;
`endif
        pop  = (state_q != ST_IDLE) && !wb_reg_wr_in;
        last = pop && (idx_q == (len_q - 3'd1));

        if (wb_reg_wr_in) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = wb_addr_in;
            rf_wr_data_d = wb_data_in;
        end else if (pop) begin
            rf_wr_en_d   = 1'b1;
            rf_wr_addr_d = base_q + {1'b0, idx_q};
            rf_wr_data_d = cx_data_in;
        end

        if (pop) begin
            idx_d = idx_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cx_req_in && (cx_len_in != 3'd0)) begin
                    state_d = ST_XFER;
                    base_d  = cx_base_addr_in;
                    len_d   = (cx_len_in > 3'd4) ? 3'd4 : cx_len_in;
                    idx_d   = 3'd0;
                end
            end
            ST_XFER: begin
                if (last) begin
                    state_d = ST_IDLE;
                end
`ifdef WB_STARVE_GUARD_EN
                else if (pop) begin
                    starve_d = 4'd0;
                end else begin
                    starve_d = starve_q + 4'd1;
                    if ((starve_q + 4'd1) >= STARVE_LIM_C) begin
                        state_d = ST_FORCE;
                    end
                end
`endif
            end
`ifdef WB_STARVE_GUARD_EN
            ST_FORCE: begin
                if (last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

`ifdef WB_STARVE_GUARD_EN
        if (state_d == ST_IDLE) begin
            starve_d = 4'd0;
        end
`endif
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            base_q       <= 4'd0;
            len_q        <= 3'd0;
            idx_q        <= 3'd0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= 4'd0;
            rf_wr_data_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign stall_out = (state_q == ST_FORCE);
`else
    assign stall_out = 1'b0;
`endif

    assign cx_pop_out     = pop;
    assign cx_done_out    = last;
    assign rf_wr_en_out   = rf_wr_en_q;
    assign rf_wr_addr_out = rf_wr_addr_q;
    assign rf_wr_data_out = rf_wr_data_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; starvation expectations follow WB_STARVE_GUARD_EN.
module tb_wb_port_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        wb_reg_wr_in;
    logic [3:0]  wb_addr_in;
    logic [15:0] wb_data_in;
    logic        cx_req_in;
    logic [3:0]  cx_base_addr_in;
    logic [2:0]  cx_len_in;
    logic [15:0] cx_data_in;
    logic        cx_pop_out;
    logic        cx_done_out;
    logic        rf_wr_en_out;
    logic [3:0]  rf_wr_addr_out;
    logic [15:0] rf_wr_data_out;
    logic        stall_out;
    logic        busy_out;
    logic [1:0]  state_dbg_out;

    int n_checks = 0;
    int n_errors = 0;

`ifdef WB_STARVE_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .wb_reg_wr_in    (wb_reg_wr_in),
        .wb_addr_in      (wb_addr_in),
        .wb_data_in      (wb_data_in),
        .cx_req_in       (cx_req_in),
        .cx_base_addr_in (cx_base_addr_in),
        .cx_len_in       (cx_len_in),
        .cx_data_in      (cx_data_in),
        .cx_pop_out      (cx_pop_out),
        .cx_done_out     (cx_done_out),
        .rf_wr_en_out    (rf_wr_en_out),
        .rf_wr_addr_out  (rf_wr_addr_out),
        .rf_wr_data_out  (rf_wr_data_out),
        .stall_out       (stall_out),
        .busy_out        (busy_out),
        .state_dbg_out   (state_dbg_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic en, input logic [3:0] addr, input logic [15:0] data);
        check_eq({tag, "_en"}, 32'(rf_wr_en_out), 32'(en));
        if (en) begin
            check_eq({tag, "_addr"}, 32'(rf_wr_addr_out), 32'(addr));
            check_eq({tag, "_data"}, 32'(rf_wr_data_out), 32'(data));
        end
    endtask

    task automatic check_comb(input string tag, input logic pop, input logic done, input logic stall, input logic busy);
        #1;
        check_eq({tag, "_pop"}, 32'(cx_pop_out), 32'(pop));
        check_eq({tag, "_done"}, 32'(cx_done_out), 32'(done));
        check_eq({tag, "_stall"}, 32'(stall_out), 32'(stall));
        check_eq({tag, "_busy"}, 32'(busy_out), 32'(busy));
    endtask

    task automatic request(input logic [3:0] base, input logic [2:0] len);
        cx_req_in       = 1'b1;
        cx_base_addr_in = base;
        cx_len_in       = len;
        cycle();
        cx_req_in       = 1'b0;
    endtask

    initial begin
        rst_in          = 1'b1;
        wb_reg_wr_in    = 1'b0;
        wb_addr_in      = 4'd0;
        wb_data_in      = 16'd0;
        cx_req_in       = 1'b0;
        cx_base_addr_in = 4'd0;
        cx_len_in       = 3'd0;
        cx_data_in      = 16'd0;

        #2;
        check_comb("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_rf("rst", 1'b0, 4'd0, 16'd0);
        check_eq("rst_state", 32'(state_dbg_out), 32'd0);
        check_eq("rst_addr", 32'(rf_wr_addr_out), 32'd0);
        check_eq("rst_data", 32'(rf_wr_data_out), 32'd0);
        cycle();
        rst_in = 1'b0;
        cycle();

        // Idle pipeline burst: r3=AAAA, r4=5555
        request(4'd3, 3'd2);
        cx_data_in = 16'hAAAA;
        check_comb("a0", 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        check_rf("a0", 1'b1, 4'd3, 16'hAAAA);
        cx_data_in = 16'h5555;
        check_comb("a1", 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        check_rf("a1", 1'b1, 4'd4, 16'h5555);
        check_comb("a_end", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_rf("a_idle", 1'b0, 4'd0, 16'd0);

        // Collision: pipeline write wins, crypto word follows
        request(4'd8, 3'd1);
        wb_reg_wr_in = 1'b1;
        wb_addr_in   = 4'd7;
        wb_data_in   = 16'h1234;
        cx_data_in   = 16'hBEEF;
        check_comb("b0", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        check_rf("b0", 1'b1, 4'd7, 16'h1234);
        wb_reg_wr_in = 1'b0;
        check_comb("b1", 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        check_rf("b1", 1'b1, 4'd8, 16'hBEEF);
        check_comb("b_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Wrap and clamp: len 7 -> 4 writes at r15, r0, r1, r2
        request(4'd15, 3'd7);
        for (int i = 0; i < 4; i++) begin
            cx_data_in = 16'hC000 + 16'(i);
            check_comb($sformatf("c%0d", i), 1'b1, (i == 3), 1'b0, 1'b1);
            cycle();
            check_rf($sformatf("c%0d", i), 1'b1, 4'(15 + i), 16'hC000 + 16'(i));
        end
        check_comb("c_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-length request is ignored
        request(4'd6, 3'd0);
        check_comb("z", 1'b0, 1'b0, 1'b0, 1'b0);
        check_rf("z", 1'b0, 4'd0, 16'd0);
        cycle();
        check_rf("z1", 1'b0, 4'd0, 16'd0);

        // Starvation: pipeline holds the port for 5 cycles during a len=3 burst
        request(4'd2, 3'd3);
        cx_data_in   = 16'hD000;
        wb_reg_wr_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb_addr_in = 4'd9;
            wb_data_in = 16'h9000 + 16'(k);
            check_comb($sformatf("s%0d", k), 1'b0, 1'b0, GUARD && (k == 4), 1'b1);
            cycle();
            check_rf($sformatf("s%0d", k), 1'b1, 4'd9, 16'h9000 + 16'(k));
        end
        wb_reg_wr_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cx_data_in = 16'hD000 + 16'(i);
            check_comb($sformatf("sp%0d", i), 1'b1, (i == 2), GUARD, 1'b1);
            cycle();
            check_rf($sformatf("sp%0d", i), 1'b1, 4'(2 + i), 16'hD000 + 16'(i));
        end
        check_comb("s_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-burst after the first pop of a len=4 burst
        request(4'd5, 3'd4);
        cx_data_in = 16'hE000;
        check_comb("r0", 1'b1, 1'b0, 1'b0, 1'b1);
        cycle();
        check_rf("r0", 1'b1, 4'd5, 16'hE000);
        #2;
        rst_in = 1'b1;
        check_comb("r_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("r_async_en", 32'(rf_wr_en_out), 32'd0);
        check_eq("r_async_addr", 32'(rf_wr_addr_out), 32'd0);
        check_eq("r_async_data", 32'(rf_wr_data_out), 32'd0);
        check_eq("r_async_state", 32'(state_dbg_out), 32'd0);
        cycle();
        check_comb("r_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        check_rf("r_hold", 1'b0, 4'd0, 16'd0);
        rst_in = 1'b0;
        check_comb("r_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        check_rf("r_rel", 1'b0, 4'd0, 16'd0);
        request(4'd1, 3'd1);
        cx_data_in = 16'hF00D;
        check_comb("r_new", 1'b1, 1'b1, 1'b0, 1'b1);
        cycle();
        check_rf("r_new", 1'b1, 4'd1, 16'hF00D);
        check_comb("r_new_end", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
